// File: rtl/ace_aw_snoop_sequencer.sv
// ACE write-address sequencer: snoops the single coherent master when the decoder asks for it,
// then forwards the registered AW beat downstream; illegal beats are dropped and counted.
package ace_aw_snoop_sequencer_pkg;
  typedef struct packed {
    logic [63:0] addr;
    logic [2:0]  prot;
    logic [3:0]  snoop;
    logic [1:0]  domain;
    logic [1:0]  bar;
    logic [5:0]  atop;
  } aw_chan_t;
  typedef logic [3:0] acsnoop_t;
endpackage

module ace_aw_snoop_sequencer #(
  parameter type aw_chan_t = ace_aw_snoop_sequencer_pkg::aw_chan_t,
  parameter type acsnoop_t = ace_aw_snoop_sequencer_pkg::acsnoop_t,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned CntWidth  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  aw_chan_t             aw_i,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  acsnoop_t             acsnoop_i,
  input  logic                 snooping_i,
  input  logic                 illegal_i,
  output logic                 ac_valid_o,
  input  logic                 ac_ready_i,
  output logic [AddrWidth-1:0] ac_addr_o,
  output acsnoop_t             ac_snoop_o,
  output logic [2:0]           ac_prot_o,
  input  logic                 cr_valid_i,
  output logic                 cr_ready_o,
  input  logic [4:0]           cr_resp_i,
  output aw_chan_t             aw_o,
  output logic                 aw_valid_o,
  input  logic                 aw_ready_i,
  output logic [4:0]           snoop_resp_o,
  output logic                 snoop_err_o,
  output logic                 illegal_o,
  output logic [CntWidth-1:0]  illegal_cnt_o
);

  typedef enum logic [2:0] {IDLE, AC_REQ, CR_WAIT, FWD, DROP} state_e;

  state_e              state_q, state_d;
  aw_chan_t            aw_q, aw_d;
  acsnoop_t            snoop_q, snoop_d;
  logic [4:0]          resp_q, resp_d;
  logic                err_q, err_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    aw_d    = aw_q;
    snoop_d = snoop_q;
    resp_d  = resp_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (aw_valid_i) begin
        aw_d    = aw_i;
        snoop_d = acsnoop_i;
        // illegal wins over snooping; the decoder flags are folded into the next state
        if (illegal_i)       state_d = DROP;
        else if (snooping_i) state_d = AC_REQ;
        else                 state_d = FWD;
      end
      AC_REQ: if (ac_ready_i) state_d = CR_WAIT;
      CR_WAIT: if (cr_valid_i) begin
        resp_d  = cr_resp_i;
        err_d   = cr_resp_i[1];
        state_d = FWD;
      end
      FWD: if (aw_ready_i) state_d = IDLE;
      DROP: begin
        if (cnt_q != {CntWidth{1'b1}}) cnt_d = cnt_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      aw_q    <= '0;
      snoop_q <= '0;
      resp_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      aw_q    <= aw_d;
      snoop_q <= snoop_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // reset forces IDLE, so ready must also be masked by rst_i itself
  assign aw_ready_o    = (state_q == IDLE) && !rst_i;
  assign ac_valid_o    = (state_q == AC_REQ);
  assign cr_ready_o    = (state_q == CR_WAIT);
  assign aw_valid_o    = (state_q == FWD);
  assign illegal_o     = (state_q == DROP);
  assign ac_addr_o     = AddrWidth'(aw_q.addr);
  assign ac_prot_o     = aw_q.prot;
  assign ac_snoop_o    = snoop_q;
  assign aw_o          = aw_q;
  assign snoop_resp_o  = resp_q;
  assign snoop_err_o   = err_q;
  assign illegal_cnt_o = cnt_q;

endmodule
